// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the two-port Data_Memory arbiter.
// Holds the default bus widths, the FSM state encoding and the legal read-latency range.
package dm_arb_pkg;

    localparam int DM_ARB_ADDR_W     = 8;
    localparam int DM_ARB_DATA_W     = 32;
    localparam int DM_ARB_RD_LAT_MIN = 1;
    localparam int DM_ARB_RD_LAT_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dm_arb_state_e;

    typedef logic dm_arb_port_t;

    localparam dm_arb_port_t PORT0 = 1'b0;
    localparam dm_arb_port_t PORT1 = 1'b1;

endpackage

// File: rtl/dm_arb_if.sv
// One requester port of the Data_Memory arbiter: req/we/addr/wdata in, one-cycle ack and held rdata out.
// The requester keeps req and all fields stable until it sees ack.
interface dm_arb_if #(
    parameter int ADDR_W = dm_arb_pkg::DM_ARB_ADDR_W,
    parameter int DATA_W = dm_arb_pkg::DM_ARB_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_arb_grant.sv
// Grant selection between the two requesters; DM_ARB_ROUND_ROBIN_EN selects round-robin, else port 0 wins.
// Combinational grant, zero latency; the round-robin pointer advances once per completed access.
module dm_arb_grant
    import dm_arb_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req0,
    input  logic         i_req1,
    input  logic         i_resp,
    input  dm_arb_port_t i_last,
    output logic         o_gnt_vld,
    output dm_arb_port_t o_gnt_idx
);

    assign o_gnt_vld = i_req0 | i_req1;

`ifdef DM_ARB_ROUND_ROBIN_EN
    // r_ptr names the port that was not served last; it wins a tie
    dm_arb_port_t r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= PORT0;
        end else if (i_resp) begin
            r_ptr <= ~i_last;
        end
    end

    always_comb begin
        o_gnt_idx = PORT0;
        if (i_req0 && i_req1) begin
            o_gnt_idx = r_ptr;
        end else if (i_req1) begin
            o_gnt_idx = PORT1;
        end
    end
`else
    logic w_unused_ok;

    assign w_unused_ok = ^{clk, reset, i_resp, i_last};
    assign o_gnt_idx   = (!i_req0 && i_req1) ? PORT1 : PORT0;
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-ported Data_Memory between CPU MEM stage (p0) and loader port (p1); grant policy via DM_ARB_ROUND_ROBIN_EN.
// Write ack 2 cycles after grant, read ack 2+MEM_RD_LAT; one access in flight, other requests held until IDLE.
module data_memory_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = DM_ARB_ADDR_W,
    parameter int DATA_W     = DM_ARB_DATA_W,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    dm_arb_if.slave           p0,
    dm_arb_if.slave           p1,
    output logic              mem_read_data_flag,
    output logic              mem_write_data_flag,
    output logic [ADDR_W-1:0] mem_address_of_data,
    output logic [DATA_W-1:0] mem_data_to_write,
    input  logic [DATA_W-1:0] mem_data_read_out,
    output logic              busy
);

    if (MEM_RD_LAT < DM_ARB_RD_LAT_MIN || MEM_RD_LAT > DM_ARB_RD_LAT_MAX) begin : g_lat_chk
        $error("data_memory_arbiter: MEM_RD_LAT must be within 1..3");
    end

    dm_arb_state_e     r_state;
    dm_arb_port_t      r_gnt;
    logic              r_we;
    logic [1:0]        r_cnt;
    logic              r_rd_flag;
    logic              r_wr_flag;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt_vld;
    dm_arb_port_t      w_gnt_idx;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    dm_arb_grant u_grant (
        .clk       (clk),
        .reset     (reset),
        .i_req0    (p0.req),
        .i_req1    (p1.req),
        .i_resp    (r_state == RESP),
        .i_last    (r_gnt),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_sel_we    = (w_gnt_idx == PORT1) ? p1.we    : p0.we;
    assign w_sel_addr  = (w_gnt_idx == PORT1) ? p1.addr  : p0.addr;
    assign w_sel_wdata = (w_gnt_idx == PORT1) ? p1.wdata : p0.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gnt     <= PORT0;
            r_we      <= 1'b0;
            r_cnt     <= 2'd0;
            r_rd_flag <= 1'b0;
            r_wr_flag <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rd_flag <= 1'b0;
            r_wr_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt     <= w_gnt_idx;
                        r_we      <= w_sel_we;
                        r_addr    <= w_sel_addr;
                        r_wr_flag <= w_sel_we;
                        r_rd_flag <= !w_sel_we;
                        if (w_sel_we) begin
                            r_wdata <= w_sel_wdata;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_ack0  <= (r_gnt == PORT0);
                        r_ack1  <= (r_gnt == PORT1);
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= 2'(MEM_RD_LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_gnt == PORT1) begin
                            r_rdata1 <= mem_data_read_out;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= mem_data_read_out;
                            r_ack0   <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_read_data_flag  = r_rd_flag;
    assign mem_write_data_flag = r_wr_flag;
    assign mem_address_of_data = r_addr;
    assign mem_data_to_write   = r_wdata;
    assign busy                = (r_state != IDLE);

    assign p0.ack   = r_ack0;
    assign p0.rdata = r_rdata0;
    assign p1.ack   = r_ack1;
    assign p1.rdata = r_rdata1;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a one-cycle-latency Data_Memory model.
// Inputs driven and outputs sampled on the falling edge; expectations adapt to DM_ARB_ROUND_ROBIN_EN.
module tb_data_memory_arbiter;

    logic        clk;
    logic        reset;
    logic        mem_read_data_flag;
    logic        mem_write_data_flag;
    logic [7:0]  mem_address_of_data;
    logic [31:0] mem_data_to_write;
    logic [31:0] mem_data_read_out;
    logic        busy;

    dm_arb_if #(.ADDR_W(8), .DATA_W(32)) p0_if ();
    dm_arb_if #(.ADDR_W(8), .DATA_W(32)) p1_if ();

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_RD_LAT(1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .p0                  (p0_if),
        .p1                  (p1_if),
        .mem_read_data_flag  (mem_read_data_flag),
        .mem_write_data_flag (mem_write_data_flag),
        .mem_address_of_data (mem_address_of_data),
        .mem_data_to_write   (mem_data_to_write),
        .mem_data_read_out   (mem_data_read_out),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Memory model: write and read sampled on the clock edge, read data one clock later
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_write_data_flag) mem[mem_address_of_data] <= mem_data_to_write;
        if (mem_read_data_flag)  mem_data_read_out <= mem[mem_address_of_data];
    end

    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int both_flag_cnt = 0;
    always @(negedge clk) begin
        if (p0_if.ack) ack0_cnt++;
        if (p1_if.ack) ack1_cnt++;
        if (mem_read_data_flag && mem_write_data_flag) both_flag_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [7:0] a, input logic [31:0] d);
        if (port) begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
        end else begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
        end
    endtask

    // Single access from an idle arbiter; lat counts falling edges until ack
    task automatic do_access(input bit port, input bit we, input logic [7:0] a, input logic [31:0] d,
                             output logic [31:0] rdata, output int lat,
                             output logic [7:0] wf, output logic [7:0] rf);
        lat = -1; wf = '0; rf = '0; rdata = '0;
        drive(port, 1'b1, we, a, d);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < 8) begin
                wf[k] = mem_write_data_flag;
                rf[k] = mem_read_data_flag;
            end
            if ((port && p1_if.ack) || (!port && p0_if.ack)) begin
                lat = k;
                rdata = port ? p1_if.rdata : p0_if.rdata;
                break;
            end
        end
        drive(port, 1'b0, 1'b0, 8'h00, 32'h0);
        if (lat < 0) check("access_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          lat;
    logic [7:0]  wf, rf;
    logic [2:0]  order;
    int          nacks, p0cnt, p1cnt, first_p1, base0, base1;
    logic [31:0] exp_val;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'hFF, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b0, 8'hEE, 32'hCAFE_F00D);

        // 1: reset held three cycles with both requests high
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ctrl", {27'd0, busy, mem_read_data_flag, mem_write_data_flag,
                               p0_if.ack, p1_if.ack}, 32'd0);
        end
        check("rst_rdata0", p0_if.rdata, 32'd0);
        check("rst_rdata1", p1_if.rdata, 32'd0);
        check("rst_addr", {24'd0, mem_address_of_data}, 32'd0);
        check("rst_wdata", mem_data_to_write, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 2: p0 write then read back; p1 write for later tests
        do_access(1'b0, 1'b1, 8'h10, 32'd5, rd, lat, wf, rf);
        check("t2_wr_lat", lat, 32'd2);
        check("t2_wr_wflag", {24'd0, wf}, 32'h02);
        check("t2_wr_rflag", {24'd0, rf}, 32'h00);
        do_access(1'b0, 1'b0, 8'h10, 32'd0, rd, lat, wf, rf);
        check("t2_rd_lat", lat, 32'd3);
        check("t2_rd_data", rd, 32'd5);
        check("t2_rd_rflag", {24'd0, rf}, 32'h02);
        do_access(1'b1, 1'b1, 8'h20, 32'd9, rd, lat, wf, rf);
        check("t2_p1_wr_lat", lat, 32'd2);

        // 3: simultaneous reads; p0 re-requests right after its first ack
        drive(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h20, 32'h0);
        order = 3'b000; nacks = 0; p0cnt = 0;
        for (int k = 0; k < 40 && nacks < 3; k++) begin
            @(negedge clk);
            if (p0_if.ack) begin
                order = {order[1:0], 1'b0}; nacks++; p0cnt++;
                check("t3_p0_data", p0_if.rdata, 32'd5);
                if (p0cnt == 2) p0_if.req = 1'b0;
            end
            if (p1_if.ack) begin
                order = {order[1:0], 1'b1}; nacks++;
                check("t3_p1_data", p1_if.rdata, 32'd9);
                p1_if.req = 1'b0;
            end
        end
        p0_if.req = 1'b0; p1_if.req = 1'b0;
        @(negedge clk);
        check("t3_nacks", nacks, 32'd3);
`ifdef DM_ARB_ROUND_ROBIN_EN
        check("t3_order", {29'd0, order}, 32'b010);
`else
        check("t3_order", {29'd0, order}, 32'b001);
`endif

        // 4: p0 held continuously, p1 raised alongside
        drive(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h20, 32'h0);
        nacks = 0; p1cnt = 0; first_p1 = 0;
        for (int k = 0; k < 60 && nacks < 4; k++) begin
            @(negedge clk);
            if (p0_if.ack) nacks++;
            if (p1_if.ack) begin
                nacks++; p1cnt++;
                if (first_p1 == 0) first_p1 = nacks;
                p1_if.req = 1'b0;
            end
        end
        p0_if.req = 1'b0;
        check("t4_nacks", nacks, 32'd4);
`ifdef DM_ARB_ROUND_ROBIN_EN
        check("t4_p1_within_2", {31'd0, (first_p1 >= 1 && first_p1 <= 2)}, 32'd1);
`else
        check("t4_p1_starved", p1cnt, 32'd0);
`endif
        for (int k = 0; k < 20 && p1_if.req; k++) begin
            @(negedge clk);
            if (p1_if.ack) begin
                p1cnt++;
                p1_if.req = 1'b0;
            end
        end
        check("t4_p1_served", p1cnt, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // 5: reset during WAIT of a p0 read
        drive(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        check("t5_rst_ctrl", {27'd0, busy, mem_read_data_flag, mem_write_data_flag,
                              p0_if.ack, p1_if.ack}, 32'd0);
        check("t5_rdata0", p0_if.rdata, 32'd0);
        check("t5_rdata1", p1_if.rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_ack", {30'd0, p0_if.ack, p1_if.ack}, 32'd0);
        do_access(1'b0, 1'b0, 8'h10, 32'd0, rd, lat, wf, rf);
        check("t5_after_lat", lat, 32'd3);
        check("t5_after_data", rd, 32'd5);

        // 6: p1 fills memory with addr^0xA5, p0 reads every word back
        base0 = ack0_cnt; base1 = ack1_cnt;
        for (int a = 0; a < 256; a++) begin
            exp_val = 32'(a) ^ 32'h0000_00A5;
            do_access(1'b1, 1'b1, 8'(a), exp_val, rd, lat, wf, rf);
        end
        for (int a = 0; a < 256; a++) begin
            exp_val = 32'(a) ^ 32'h0000_00A5;
            do_access(1'b0, 1'b0, 8'(a), 32'h0, rd, lat, wf, rf);
            check("t6_readback", rd, exp_val);
        end
        check("t6_p1_acks", ack1_cnt - base1, 32'd256);
        check("t6_p0_acks", ack0_cnt - base0, 32'd256);
        check("flags_exclusive", both_flag_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
